// File: rtl/dpram_burst_reader_if.sv
// dpram_burst_reader_if: valid/ready word stream carrying burst data and an end-of-burst marker
interface dpram_burst_reader_if #(
  parameter int DATA_W = 32
);
  logic m_valid;
  logic m_ready;
  logic m_last;
  logic [DATA_W-1:0] m_data;
  modport master(output m_valid, m_data, m_last, input m_ready);
  modport slave(input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/dpram_burst_reader.sv
// dpram_burst_reader: dual-port RAM burst fetcher serialising onto a valid/ready stream; DPRAM_BURST_READER_WORD_COUNT_EN adds word_count
module dpram_burst_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
  output logic busy,
  output logic done,
  output logic [ADDR_W-1:0] addr_out_0,
  output logic [ADDR_W-1:0] addr_out_1,
  output logic port_en_0,
  output logic port_en_1,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
`ifdef DPRAM_BURST_READER_WORD_COUNT_EN
  output logic [15:0] word_count,
`endif
  dpram_burst_reader_if.master m
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr, addr_q0, addr_q1;
  logic [ADDR_W:0] issue_left, out_left;
  logic iss0_q, iss1_q, pop;
  logic [1:0] n_iss, n_push;
  logic [PW:0] cnt;
  logic [PW-1:0] wp, hp;
  logic [PW+1:0] occ;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  assign n_push = {1'b0, iss0_q} + {1'b0, iss1_q};
  assign occ = {1'b0, cnt} + (PW+2)'(n_push);
  assign pop = m.m_valid & m.m_ready;
  assign m.m_valid = cnt != '0;
  assign m.m_data = m.m_valid ? mem[hp] : '0;
  assign m.m_last = m.m_valid && out_left == (ADDR_W+1)'(1);

  // Issue reads only while FIFO plus in-flight words leave room for two more; status and next state
  always_comb begin
    state_nxt = state;
    port_en_0 = state == FETCH && occ <= (PW+2)'(FIFO_DEPTH - 2);
    port_en_1 = port_en_0 && issue_left > (ADDR_W+1)'(1);
    n_iss = {1'b0, port_en_0} + {1'b0, port_en_1};
    addr_out_0 = port_en_0 ? rd_ptr : addr_q0;
    addr_out_1 = port_en_1 ? rd_ptr + ADDR_W'(1) : addr_q1;
    done = state == DRAIN && out_left == '0;
    busy = state != IDLE && !done;
    if (state == IDLE && start) state_nxt = FETCH;
    if (state == FETCH && issue_left == (ADDR_W+1)'(n_iss)) state_nxt = DRAIN;
    if (done) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;

  // Burst counters, held addresses, issue flags and FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      issue_left <= '0;
      out_left <= '0;
      addr_q0 <= '0;
      addr_q1 <= '0;
      iss0_q <= 1'b0;
      iss1_q <= 1'b0;
      cnt <= '0;
      wp <= '0;
      hp <= '0;
    end else begin
      iss0_q <= port_en_0;
      iss1_q <= port_en_1;
      addr_q0 <= addr_out_0;
      addr_q1 <= addr_out_1;
      wp <= wp + PW'(n_push);
      hp <= hp + PW'(pop);
      cnt <= cnt + (PW+1)'(n_push) - (PW+1)'(pop);
      if (state == IDLE && start) begin
        rd_ptr <= base_addr;
        issue_left <= {1'b0, len_m1} + (ADDR_W+1)'(1);
        out_left <= {1'b0, len_m1} + (ADDR_W+1)'(1);
      end else begin
        rd_ptr <= rd_ptr + ADDR_W'(n_iss);
        issue_left <= issue_left - (ADDR_W+1)'(n_iss);
        out_left <= out_left - (ADDR_W+1)'(pop);
      end
    end
  end

  // Capture registered RAM data one cycle after issue; port 1 only issues alongside port 0
  always_ff @(posedge clk) begin
    if (iss0_q) mem[wp] <= data_out_0;
    if (iss1_q) mem[wp + PW'(1)] <= data_out_1;
  end

`ifdef DPRAM_BURST_READER_WORD_COUNT_EN
  // Count accepted stream words since reset
  always_ff @(posedge clk) word_count <= reset ? 16'd0 : word_count + 16'(pop);
`endif
endmodule

// File: tb/tb_dpram_burst_reader.sv
// tb_dpram_burst_reader: scoreboard bench with a registered dual-port RAM model
module tb_dpram_burst_reader;
  logic clk = 0, reset = 1, start = 0;
  logic [4:0] base_addr = 0, len_m1 = 0, addr_out_0, addr_out_1;
  logic busy, done, port_en_0, port_en_1;
  logic [31:0] data_out_0, data_out_1;
  logic [31:0] ram [32];
  logic [32:0] exp_q[$], obs_q[$];
  logic [4:0] iss_q[$];
  int total = 0, bad = 0;
  int m_cnt = 0, inflight = 0, viol = 0, p1_cnt = 0;
  int first_c, last_c, done_c, done_n, stable_err;
  logic busy_at_done;
`ifdef DPRAM_BURST_READER_WORD_COUNT_EN
  logic [15:0] word_count;
`endif

  dpram_burst_reader_if #(.DATA_W(32)) s();

  dpram_burst_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len_m1(len_m1),
    .busy(busy), .done(done), .addr_out_0(addr_out_0), .addr_out_1(addr_out_1),
    .port_en_0(port_en_0), .port_en_1(port_en_1),
    .data_out_0(data_out_0), .data_out_1(data_out_1),
`ifdef DPRAM_BURST_READER_WORD_COUNT_EN
    .word_count(word_count),
`endif
    .m(s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_out_0 <= port_en_0 ? ram[addr_out_0] : 32'hdead_0000;
    data_out_1 <= port_en_1 ? ram[addr_out_1] : 32'hdead_0001;
  end

  always @(negedge clk) begin
    if (port_en_0) iss_q.push_back(addr_out_0);
    if (port_en_1) begin
      iss_q.push_back(addr_out_1);
      p1_cnt++;
    end
    if (m_cnt + inflight + int'(port_en_0) + int'(port_en_1) > 4) viol++;
    m_cnt = m_cnt + inflight - int'(s.m_valid && s.m_ready);
    inflight = int'(port_en_0) + int'(port_en_1);
    if (reset) begin
      m_cnt = 0;
      inflight = 0;
    end
  end

  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    start = 1;
    base_addr = b[4:0];
    len_m1 = l[4:0];
    for (int i = 0; i <= l; i++) exp_q.push_back({i == l, 32'(32'h100 + (b + i) % 32)});
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic collect(input int n, input int mode, input int pulse_at, input bit need_done);
    logic [32:0] held = '0;
    bit stalled = 0;
    int c = 0;
    obs_q.delete();
    first_c = -1; last_c = -1; done_c = -1; done_n = 0; stable_err = 0; busy_at_done = 1;
    while (c < 400 && !(obs_q.size() >= n && (!need_done || done_n > 0))) begin
      @(posedge clk); #1;
      s.m_ready = (mode == 0) || (c % 3 == 0);
      start = (c == pulse_at) || (pulse_at == -2 && done);
      base_addr = 5'd20;
      len_m1 = 5'd2;
      @(negedge clk);
      if (stalled && s.m_valid && {s.m_last, s.m_data} !== held) stable_err++;
      stalled = s.m_valid && !s.m_ready;
      held = {s.m_last, s.m_data};
      if (s.m_valid && first_c < 0) first_c = c;
      if (s.m_valid && s.m_ready) begin
        obs_q.push_back({s.m_last, s.m_data});
        last_c = c;
      end
      if (done) begin
        done_n++;
        done_c = c;
        busy_at_done = busy;
      end
      c++;
    end
    start = 0;
    s.m_ready = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, port_en_0, port_en_1, addr_out_0, addr_out_1, s.m_valid, s.m_data, s.m_last} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b en=%b%b a0=%0d a1=%0d v=%b d=%h l=%b want all 0",
               busy, done, port_en_0, port_en_1, addr_out_0, addr_out_1, s.m_valid, s.m_data, s.m_last);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_basic;
    logic [32:0] e;
    do_start(0, 7);
    collect(8, 0, -1, 1);
    total++;
    if (obs_q.size() != 8) begin bad++; $display("FAIL basic_count got=%0d want=8", obs_q.size()); end
    foreach (obs_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[i] !== e) begin bad++; $display("FAIL basic_word%0d got=%h want=%h", i, obs_q[i], e); end
    end
    exp_q.delete();
    total++;
    if (first_c > 1) begin bad++; $display("FAIL basic_latency got=%0d want<=1", first_c); end
    total++;
    if (last_c - first_c != 7) begin bad++; $display("FAIL basic_sustain got=%0d want=7", last_c - first_c); end
    total++;
    if (done_c != last_c + 1) begin bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", done_c, last_c + 1); end
    total++;
    if (done_n != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_n); end
    total++;
    if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy_at_done); end
  endtask

  task automatic test_wrap;
    logic [32:0] e;
    logic [4:0] wa [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    int idx = iss_q.size();
    do_start(30, 3);
    collect(4, 0, -1, 1);
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", obs_q.size()); end
    foreach (obs_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[i] !== e) begin bad++; $display("FAIL wrap_word%0d got=%h want=%h", i, obs_q[i], e); end
    end
    exp_q.delete();
    total++;
    if (iss_q.size() - idx != 4) begin bad++; $display("FAIL wrap_issue_count got=%0d want=4", iss_q.size() - idx); end
    for (int i = 0; i < 4 && idx + i < iss_q.size(); i++) begin
      total++;
      if (iss_q[idx + i] !== wa[i]) begin bad++; $display("FAIL wrap_addr%0d got=%0d want=%0d", i, iss_q[idx + i], wa[i]); end
    end
  endtask

  task automatic test_len1;
    int p1 = p1_cnt;
    do_start(5, 0);
    collect(1, 0, -1, 1);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 32'h105}) begin
      bad++;
      $display("FAIL len1_word got=%h size=%0d want=%h", obs_q.size() > 0 ? obs_q[0] : 33'h0, obs_q.size(), {1'b1, 32'h105});
    end
    exp_q.delete();
    total++;
    if (p1_cnt != p1) begin bad++; $display("FAIL len1_port1 got=%0d want=0", p1_cnt - p1); end
  endtask

  task automatic test_backpressure;
    logic [32:0] e;
    do_start(0, 31);
    collect(32, 1, -1, 1);
    total++;
    if (obs_q.size() != 32) begin bad++; $display("FAIL bp_count got=%0d want=32", obs_q.size()); end
    foreach (obs_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[i] !== e) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", i, obs_q[i], e); end
    end
    exp_q.delete();
    total++;
    if (stable_err != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stable_err); end
    total++;
    if (viol != 0) begin bad++; $display("FAIL bp_credit got=%0d want=0", viol); end
  endtask

  task automatic test_ignore_start;
    logic [32:0] e;
    int act = 0;
    do_start(0, 7);
    collect(8, 0, 3, 1);
    total++;
    if (obs_q.size() != 8) begin bad++; $display("FAIL ign_count got=%0d want=8", obs_q.size()); end
    foreach (obs_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[i] !== e) begin bad++; $display("FAIL ign_word%0d got=%h want=%h", i, obs_q[i], e); end
    end
    exp_q.delete();
    do_start(8, 3);
    collect(4, 0, -2, 1);
    foreach (obs_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[i] !== e) begin bad++; $display("FAIL ign_done_word%0d got=%h want=%h", i, obs_q[i], e); end
    end
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (busy || s.m_valid) act++;
    end
    total++;
    if (act != 0) begin bad++; $display("FAIL ign_start_at_done got=%0d active cycles want=0", act); end
  endtask

  task automatic test_reset_mid;
    logic [32:0] e;
    do_start(0, 15);
    collect(3, 1, -1, 0);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, port_en_0, port_en_1, addr_out_0, addr_out_1, s.m_valid, s.m_data, s.m_last} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got busy=%b done=%b en=%b%b a0=%0d a1=%0d v=%b d=%h l=%b want all 0",
               busy, done, port_en_0, port_en_1, addr_out_0, addr_out_1, s.m_valid, s.m_data, s.m_last);
    end
    @(posedge clk); #1;
    reset = 0;
    exp_q.delete();
    do_start(10, 4);
    collect(5, 0, -1, 1);
    total++;
    if (obs_q.size() != 5) begin bad++; $display("FAIL midreset_count got=%0d want=5", obs_q.size()); end
    foreach (obs_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[i] !== e) begin bad++; $display("FAIL midreset_word%0d got=%h want=%h", i, obs_q[i], e); end
    end
    exp_q.delete();
  endtask

`ifdef DPRAM_BURST_READER_WORD_COUNT_EN
  task automatic test_word_count;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (word_count !== 16'd0) begin bad++; $display("FAIL wc_reset got=%0d want=0", word_count); end
    @(posedge clk); #1;
    reset = 0;
    do_start(0, 7);
    collect(8, 0, -1, 1);
    do_start(3, 2);
    collect(3, 0, -1, 1);
    exp_q.delete();
    total++;
    if (word_count !== 16'd11) begin bad++; $display("FAIL wc_total got=%0d want=11", word_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'h100 + i;
    s.m_ready = 0;
    test_reset;
    test_basic;
    test_wrap;
    test_len1;
    test_backpressure;
    test_ignore_start;
    test_reset_mid;
`ifdef DPRAM_BURST_READER_WORD_COUNT_EN
    test_word_count;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpram_burst_reader.md
Name: dpram_burst_reader

Overview:
- Read-side sequencer for the 32x32 dual-port RAM.
- Accepts a burst command (base address, length) and drives both RAM read ports to fetch two words per cycle.
- Captures the registered RAM outputs one cycle later and serialises them onto a 32-bit valid/ready stream with backpressure.
- Sits directly downstream of the RAM; clk drives the RAM's read_clk.

Parameters:
- DATA_W, 32, RAM word width and stream data width.
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 4.

Ports:
- clk  in  1  single clock; also drives RAM read_clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only when busy=0.
- base_addr  in  ADDR_W  first RAM address of the burst.
- len_m1  in  ADDR_W  burst length minus 1 (1..32 words).
- busy  out  1  high from the cycle after command acceptance until the last word is accepted.
- done  out  1  one-cycle pulse in the cycle after the last word is accepted.
- addr_out_0  out  ADDR_W  RAM read address, port 0.
- addr_out_1  out  ADDR_W  RAM read address, port 1.
- port_en_0  out  1  RAM port 0 enable (read issue).
- port_en_1  out  1  RAM port 1 enable (read issue).
- data_out_0  in  DATA_W  RAM registered read data, port 0.
- data_out_1  in  DATA_W  RAM registered read data, port 1.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_W  stream word.
- m_last  out  1  marks the final word of the burst.

Behaviour:
- Reset, synchronous, active-high, overrides everything.
  - All outputs go to 0: busy, done, port_en_0/1, addr_out_0/1, m_valid, m_data, m_last.
  - FIFO is emptied, FSM returns to IDLE, and data from any in-flight read is discarded.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 latches base_addr into rd_ptr, len_m1+1 into issue_left (6 bits) and into out_left.
  - Next state FETCH; busy=1 from the next cycle.
- FETCH, issue condition: issue when FIFO free entries minus in-flight words is at least 2.
  - Port 0 always issues: addr_out_0=rd_ptr, port_en_0=1.
  - If issue_left>=2, port 1 also issues: addr_out_1=rd_ptr+1, port_en_1=1.
  - rd_ptr and issue_left advance by the number of words issued.
  - Otherwise port_en_0/1=0 and addresses hold.
  - Goes to DRAIN once issue_left reaches 0.
- Read latency: the RAM returns data one clock after issue.
  - The block registers the per-port issue flags and, in the next cycle, pushes data_out_0 then data_out_1, only for ports that issued.
  - Data from a non-enabled port is high-Z and is never sampled.
- Address arithmetic: modulo 2**ADDR_W. Example: base 30, len 4 reads 30,31,0,1. rd_ptr+1 wraps the same way.
- Stream:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - A pop occurs when m_valid && m_ready.
  - m_data and m_last must hold stable while m_valid=1 and m_ready=0.
  - m_last=1 on the word for which out_left==1.
- DRAIN: waits for out_left to reach 0, then the block returns to IDLE, pulses done for one cycle, and drops busy in the same cycle.
- start while busy=1: ignored, no latch, no error.
- start in the same cycle as done: ignored; a new command is accepted from the next cycle.
- Simultaneous FIFO push (up to 2) and pop in one cycle is supported.
  - The credit rule guarantees the FIFO never overflows.
  - The FIFO never underflows; pop is gated by m_valid.
- Throughput: with m_ready held 1, the first word appears 2 cycles after start; one word per cycle is sustained thereafter.
- Length-1 burst: single port-0 issue; port_en_1 stays 0 for the whole burst.

Optional Feature:
- Macro: DPRAM_BURST_READER_WORD_COUNT_EN.
- Defined:
  - Adds output word_count [15:0]: count of stream words accepted (m_valid && m_ready) since reset.
  - Wraps at 65535→0; cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- RAM preloaded mem[i]=i+0x100. Start base=0, len_m1=7, m_ready=1 → 0x100..0x107 in order, m_last only on 0x107, done one cycle after, busy low in the done cycle.
- Start base=30, len_m1=3 → addresses 30,31,0,1 issued. Stream 0x11E,0x11F,0x100,0x101.
- Start base=5, len_m1=0 → single word 0x105 with m_last=1; port_en_1 never asserted.
- Start base=0, len_m1=31, m_ready toggled 1-in-3 → all 32 words in order with no loss or duplication; m_data stable while stalled; in-flight words never exceed FIFO free entries.
- start pulsed mid-burst with a different base → ignored; the first burst completes unchanged. Reset asserted mid-burst → next cycle all outputs 0 and FIFO empty; a new burst then runs correctly.
- With DPRAM_BURST_READER_WORD_COUNT_EN: two bursts of 8 and 3 words → word_count=11 after the second done.
